// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared MAR/MDR memory port.
// Optional ACCESS timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    rw,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               err,
  output logic               busy,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic               mem_EN,
  output logic               mem_RW,
  input  logic [DW-1:0]      mem_rdata,
  input  logic               MFC
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic [IW-1:0] ptr_d;
  logic          found;

  logic [AW-1:0] addr_a  [NREQ];
  logic [DW-1:0] wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = addr[g*AW +: AW];
    assign wdata_a[g] = wdata[g*DW +: DW];
  end

  // Scan offsets high to low so the requester nearest the pointer wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_EN    <= 1'b0;
      mem_RW    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      err       <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      ack <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (found) begin
            idx_q     <= sel;
            gnt       <= '0;
            gnt[sel]  <= 1'b1;
            busy      <= 1'b1;
            mem_addr  <= addr_a[sel];
            mem_wdata <= wdata_a[sel];
            mem_RW    <= rw[sel];
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          mem_EN  <= 1'b1;
          state_q <= ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        ACCESS: begin
          if (MFC) begin
            mem_EN  <= 1'b0;
            ack     <= gnt;
            rdata   <= mem_RW ? mem_rdata : '0;
            ptr_q   <= ptr_d;
            state_q <= DONE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            mem_EN  <= 1'b0;
            ack     <= gnt;
            err     <= 1'b1;
            rdata   <= '0;
            ptr_q   <= ptr_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        DONE: begin
          gnt     <= '0;
          busy    <= 1'b0;
          rdata   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus
// randomized transactions against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int NREQ    = 3;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 15;
  localparam int IW      = $clog2(NREQ);

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req, rw, gnt, ack;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]      mem_addr;
  logic               err, busy, mem_EN, mem_RW, MFC;

  int n_chk = 0;
  int n_err = 0;
  int ptr   = 0;
  int w;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw),
    .addr(addr), .wdata(wdata), .gnt(gnt), .ack(ack),
    .rdata(rdata), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_EN(mem_EN), .mem_RW(mem_RW),
    .mem_rdata(mem_rdata), .MFC(MFC)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] oh(input int i);
    return 32'(1) << i;
  endfunction

  function automatic logic bit_of(input logic [NREQ-1:0] v, input int j);
    logic [IW-1:0] jj;
    jj = IW'(j);
    return v[jj];
  endfunction

  // Round-robin rule: first pending requester at or after the pointer.
  function automatic int pick();
    for (int k = 0; k < NREQ; k++)
      if (bit_of(req, (ptr + k) % NREQ)) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
    chk({tag, "_en"}, mem_EN, 0);
    chk({tag, "_rw"}, mem_RW, 0);
  endtask

  // Called at a negedge in IDLE with req already set; ends at the
  // negedge of the IDLE cycle following DONE.
  task automatic txn(input int d, input bit wd, input bit scr,
                     input logic [DW-1:0] rdv, output int win);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          erw;
    logic [IW-1:0] wi;
    win = pick();
    wi  = IW'(win);
    ea  = addr[win*AW +: AW];
    ed  = wdata[win*DW +: DW];
    erw = rw[wi];
    @(negedge clk);
    chk("setup_gnt", gnt, oh(win));
    chk("setup_busy", busy, 1);
    chk("setup_en", mem_EN, 0);
    chk("setup_addr", mem_addr, ea);
    chk("setup_wdata", mem_wdata, ed);
    chk("setup_rw", mem_RW, erw);
    chk("setup_ack", ack, 0);
    if (wd) req[wi] = 1'b0;
    if (scr) begin
      addr[win*AW +: AW]  = ~ea;
      wdata[win*DW +: DW] = ~ed;
      rw[wi]              = ~erw;
    end
    MFC = 1'($urandom);
    for (int k = 0; k <= d; k++) begin
      @(negedge clk);
      chk("acc_en", mem_EN, 1);
      chk("acc_rw", mem_RW, erw);
      chk("acc_addr", mem_addr, ea);
      chk("acc_wdata", mem_wdata, ed);
      chk("acc_gnt", gnt, oh(win));
      chk("acc_ack", ack, 0);
      MFC       = (k == d);
      mem_rdata = (k == d) ? rdv : DW'($urandom);
    end
    @(negedge clk);
    chk("done_ack", ack, oh(win));
    chk("done_gnt", gnt, oh(win));
    chk("done_rdata", rdata, erw ? rdv : '0);
    chk("done_err", err, 0);
    chk("done_en", mem_EN, 0);
    chk("done_busy", busy, 1);
    ptr       = (win + 1) % NREQ;
    req[wi]   = 1'b0;
    MFC       = 1'($urandom);
    mem_rdata = DW'($urandom);
    @(negedge clk);
    chk("idle_gnt", gnt, 0);
    chk("idle_ack", ack, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rdata", rdata, 0);
    chk("idle_en", mem_EN, 0);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic to_txn(input bit last);
    logic [IW-1:0] wi;
    logic [DW-1:0] rdv;
    wi      = IW'(ptr);
    rdv     = DW'($urandom);
    req     = '0;
    req[wi] = 1'b1;
    rw[wi]  = 1'b1;
    MFC     = 1'b0;
    @(negedge clk);
    chk("to_setup_gnt", gnt, oh(ptr));
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      chk("to_en", mem_EN, 1);
      chk("to_noack", ack, 0);
      MFC       = last && (k == TIMEOUT - 1);
      mem_rdata = rdv;
    end
    @(negedge clk);
    chk("to_ack", ack, oh(ptr));
    chk("to_err", err, !last);
    chk("to_rdata", rdata, last ? rdv : '0);
    req[wi] = 1'b0;
    ptr     = (ptr + 1) % NREQ;
    MFC     = 1'b0;
    @(negedge clk);
    chk("to_idle", busy, 0);
    chk("to_idle_err", err, 0);
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; rw = '0; addr = '0; wdata = '0;
    mem_rdata = '0; MFC = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("rst0");
    rst = 1'b0;

    req = 3'b001; rw = 3'b001; addr[0 +: AW] = 16'h0004;
    txn(1, 0, 0, 16'hBEEF, w);

    req = 3'b010; rw = 3'b000;
    addr[AW +: AW] = 16'h0020; wdata[DW +: DW] = 16'h1234;
    txn(0, 0, 0, 16'hDEAD, w);

    req = 3'b011; rw = 3'b011;
    for (int t = 0; t < 4; t++) begin
      txn($urandom_range(0, 2), 0, 0, DW'($urandom), w);
      req[IW'(w)] = 1'b1;
    end

    req = 3'b001;
    txn(2, 1, 1, 16'h5A5A, w);
    req = '1;
    txn(1, 0, 0, 16'hA5A5, w);

    req = '0; MFC = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_mfc_gnt", gnt, 0);
      chk("idle_mfc_busy", busy, 0);
      chk("idle_mfc_en", mem_EN, 0);
    end
    MFC = 1'b0;

    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bit_of(req, i)) begin
          req[IW'(i)]       = 1'($urandom);
          rw[IW'(i)]        = 1'($urandom);
          addr[i*AW +: AW]  = AW'($urandom);
          wdata[i*DW +: DW] = DW'($urandom);
        end
      end
      if (req == '0) req[IW'($urandom_range(0, NREQ - 1))] = 1'b1;
      txn($urandom_range(0, 4), $urandom_range(0, 3) == 0,
          1'($urandom), DW'($urandom), w);
    end

    req = 3'b010; rw = '0;
    txn(0, 0, 0, 16'h0, w);
    req = 3'b001; MFC = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_en", mem_EN, 1);
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk_zero("rst_mid1");
    @(negedge clk);
    chk_zero("rst_mid2");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("rst_after");
    ptr = 0;
    req = '1; rw[0] = 1'b1; addr[0 +: AW] = 16'h0010;
    txn(1, 0, 0, 16'hCAFE, w);

`ifdef MEM_ARB_TIMEOUT_EN
    to_txn(1'b0);
    to_txn(1'b1);
`else
    req = '0; req[IW'(ptr)] = 1'b1; rw[IW'(ptr)] = 1'b1;
    txn(20, 0, 0, 16'h7E57, w);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
